uart_tx_param: RTL and testbench

Parametrised UART transmitter with an integrated transmit FIFO. It is the successor to the fixed 8N1 `uart_tx`, with configurable data width, parity, stop bits, bit period and buffer depth. It sits between on-chip producers (loopback logic, CPU peripheral bus) and the `UART_TX` pin, and is used both in `chip` and as the stimulus driver in testbenches. Producers can queue several characters and streaming continues back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_fifo.sv | 57 +++++
 rtl/uart_tx_param.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_param.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
//   tx_state_t     : serializer FSM states
//   PAR_*          : parity mode encodings for the PARITY parameter
//   frame_cycles() : clock cycles occupied by one complete frame on the line
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   function automatic int unsigned frame_cycles(input int unsigned clk_div,
                                                input int unsigned data_bits,
                                                input int unsigned parity,
                                                input int unsigned stop_bits);
      return clk_div * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Generic synchronous FIFO with first-word fall-through read data.
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   push, wdata   : write request and data (ignored while full)
//   pop, rdata    : read request (ignored while empty); rdata shows the head word
//   full, empty   : status decoded from the pointers
//   level         : number of stored words
module uart_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_fifo: DEPTH must be a power of 2 and >= 2");
   end

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an integrated transmit FIFO.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   tx_req      : producer offers tx_data; accepted when tx_ready is high
//   tx_ready    : FIFO has room for another word
//   tx_data     : character to send, LSB first
//   uart_tx     : serial line, idles high
//   busy        : frame on the line or words still queued
//   fifo_level  : queued words, excluding the frame in flight
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV    = 104,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tx_req,
   output logic                          tx_ready,
   input  logic [DATA_BITS-1:0]          tx_data,
   output logic                          uart_tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   if (CLK_DIV < 2) begin : g_bad_div
      $error("uart_tx_param: CLK_DIV must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("uart_tx_param: DATA_BITS must be in 5..9");
   end
   if (PARITY > PAR_EVEN) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_param: FIFO_DEPTH must be a power of 2 and >= 2");
   end

   localparam int unsigned CNTW = $clog2(CLK_DIV);
   localparam int unsigned IDXW = $clog2(DATA_BITS);
   localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(CLK_DIV - 1);
   localparam logic [IDXW-1:0] DATA_LAST = IDXW'(DATA_BITS - 1);
   localparam logic [IDXW-1:0] STOP_LAST = IDXW'(STOP_BITS - 1);

   tx_state_t            state, state_n;
   logic [CNTW-1:0]      cnt, cnt_n;
   logic [IDXW-1:0]      idx, idx_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic                 par_bit, par_n;
   logic                 nonempty_q;
   logic                 bit_end;
   logic                 load;
   logic                 push;
   logic                 line_n;
   logic                 busy_n;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic                 fifo_full;
   logic                 fifo_empty;

   assign push     = tx_req && tx_ready;
   assign tx_ready = !fifo_full;

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (tx_data),
      .pop   (load),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // State and datapath registers. The line and busy are registered from the
   // next-state values so they change on the same edge as the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         nonempty_q <= 1'b0;
         uart_tx    <= 1'b1;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         shreg      <= shreg_n;
         par_bit    <= par_n;
         nonempty_q <= !fifo_empty;
         uart_tx    <= line_n;
         busy       <= busy_n;
      end
   end

   // Next-state logic. Starting a frame waits on the one-cycle-delayed
   // non-empty flag, so a word accepted at edge N is popped at edge N+2.
   // A pop never happens within a frame time of the previous one, so the
   // delayed flag cannot be stale when it is consulted.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      par_n   = par_bit;
      load    = 1'b0;
      bit_end = (cnt == CNT_LAST);

      if (state != ST_IDLE) cnt_n = bit_end ? '0 : cnt + 1'b1;

      case (state)
         ST_IDLE: begin
            if (nonempty_q) begin
               state_n = ST_START;
               load    = 1'b1;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_n = ST_DATA;
               idx_n   = '0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shreg_n = shreg >> 1;
               if (idx == DATA_LAST) begin
                  idx_n   = '0;
                  state_n = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_n = ST_STOP;
               idx_n   = '0;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (idx == STOP_LAST) begin
                  idx_n = '0;
                  if (nonempty_q) begin
                     state_n = ST_START;
                     load    = 1'b1;
                  end else begin
                     state_n = ST_IDLE;
                  end
               end else begin
                  idx_n = idx + 1'b1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (load) begin
         shreg_n = fifo_rdata;
         par_n   = (^fifo_rdata) ^ (PARITY == PAR_ODD);
      end
   end

   // Output decode from the next state. No pop happens when heading to IDLE,
   // so the queue stays non-empty after the edge if it holds a word now or
   // is being pushed.
   always_comb begin
      case (state_n)
         ST_START:  line_n = 1'b0;
         ST_DATA:   line_n = shreg_n[0];
         ST_PARITY: line_n = par_n;
         default:   line_n = 1'b1;
      endcase
      busy_n = (state_n != ST_IDLE) || (fifo_level != '0) || push;
   end

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;
   import uart_pkg::*;

   logic       clk;
   logic       reset;
   logic [2:0] req;
   logic [2:0] ready;
   logic [2:0] line;
   logic [2:0] busy;
   logic [7:0] data  [3];
   logic [2:0] level [3];

   int checks   = 0;
   int failures = 0;

   // dut 0: 8N1, dut 1: 8E2, dut 2: 8O2; all CLK_DIV=4, depth 4
   uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_n (
      .clk(clk), .reset(reset), .tx_req(req[0]), .tx_ready(ready[0]), .tx_data(data[0]),
      .uart_tx(line[0]), .busy(busy[0]), .fifo_level(level[0]));
   uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_e (
      .clk(clk), .reset(reset), .tx_req(req[1]), .tx_ready(ready[1]), .tx_data(data[1]),
      .uart_tx(line[1]), .busy(busy[1]), .fifo_level(level[1]));
   uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_o (
      .clk(clk), .reset(reset), .tx_req(req[2]), .tx_ready(ready[2]), .tx_data(data[2]),
      .uart_tx(line[2]), .busy(busy[2]), .fifo_level(level[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Bit b of a frame: 0 start, 1..8 data LSB first, 9 parity if enabled, then stop.
   function automatic logic frame_bit(input logic [7:0] d, input logic par, input int pmode, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (pmode != 0 && b == 9) return par;
      return 1'b1;
   endfunction

   // Expected line k cycles after the accepting edge of a lone word.
   function automatic logic exp_line(input logic [7:0] d, input logic par, input int pmode,
                                     input int sbits, input int k);
      int nbits;
      nbits = int'(frame_cycles(4, 8, pmode, sbits)) / 4;
      if (k < 2) return 1'b1;
      if ((k - 2) / 4 < nbits) return frame_bit(d, par, pmode, (k - 2) / 4);
      return 1'b1;
   endfunction

   typedef struct {
      logic [7:0] d;
      logic       even_par;
      logic       odd_par;
   } vec_t;

   vec_t tbl [7];

   // Serial receiver for dut 2 (8O2)
   logic [7:0] exp_q [$];
   logic       rx_on = 1'b0;
   int         rx_count = 0;

   initial begin
      logic [11:0] bits;
      logic [11:0] expf;
      logic [7:0]  d;
      forever begin
         @(negedge clk);
         if (rx_on && line[2] === 1'b0) begin
            repeat (2) @(negedge clk);
            bits[0] = line[2];
            for (int b = 1; b < 12; b++) begin
               repeat (4) @(negedge clk);
               bits[b] = line[2];
            end
            if (exp_q.size() == 0) begin
               check_eq("rx_unexpected_frame", 32'(bits), 32'hFFF);
            end else begin
               d = exp_q.pop_front();
               expf = {2'b11, (($countones(d) % 2) == 0) ? 1'b1 : 1'b0, d, 1'b0};
               check_eq("rx_frame", 32'(bits), 32'(expf));
            end
            rx_count++;
         end
      end
   end

   initial begin
      logic [7:0] hello [5];
      logic [7:0] sp    [4];
      logic [7:0] rs    [4];
      logic       rdy_b;
      logic       e_bit;
      int         mism [3];
      int         m;
      int         n_acc;
      int         sent;
      int         guard;

      tbl[0] = '{8'h48, 1'b0, 1'b1};
      tbl[1] = '{8'h00, 1'b0, 1'b1};
      tbl[2] = '{8'h01, 1'b1, 1'b0};
      tbl[3] = '{8'h55, 1'b0, 1'b1};
      tbl[4] = '{8'hA7, 1'b1, 1'b0};
      tbl[5] = '{8'h80, 1'b1, 1'b0};
      tbl[6] = '{8'h7E, 1'b0, 1'b1};
      hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
      sp    = '{8'h3C, 8'hA5, 8'h0F, 8'h99};
      rs    = '{8'h11, 8'hC3, 8'h77, 8'h22};

      reset = 1'b1;
      req   = '0;
      for (int i = 0; i < 3; i++) data[i] = '0;

      // Reset held: line idle, ready, not busy, empty
      for (int c = 0; c < 10; c++) begin
         step();
         check_eq("reset_hold", {28'd0, line[0], ready[0], busy[0], 1'b0} | 32'(level[0]), 32'hC);
      end
      reset = 1'b0;
      repeat (3) step();

      // Single frames on all three configurations
      for (int r = 0; r < 7; r++) begin
         req = 3'b111;
         for (int i = 0; i < 3; i++) data[i] = tbl[r].d;
         step();
         req = '0;
         check_eq("accept_level", 32'(level[0]), 32'd1);
         check_eq("accept_busy", 32'(busy[0]), 32'd1);
         mism = '{0, 0, 0};
         for (int k = 1; k < 56; k++) begin
            step();
            if (line[0] !== exp_line(tbl[r].d, 1'b0, 0, 1, k)) mism[0]++;
            if (line[1] !== exp_line(tbl[r].d, tbl[r].even_par, 2, 2, k)) mism[1]++;
            if (line[2] !== exp_line(tbl[r].d, tbl[r].odd_par, 1, 2, k)) mism[2]++;
            if (k == 2)  check_eq("pop_level", 32'(level[0]), 32'd0);
            if (k == 41) check_eq("busy_last_8n1", 32'(busy[0]), 32'd1);
            if (k == 42) check_eq("busy_fall_8n1", 32'(busy[0]), 32'd0);
            if (k == 49) check_eq("busy_last_8e2", 32'(busy[1]), 32'd1);
            if (k == 50) check_eq("busy_fall_8e2", 32'(busy[1]), 32'd0);
         end
         check_eq("frame_8n1", 32'(mism[0]), 32'd0);
         check_eq("frame_8e2", 32'(mism[1]), 32'd0);
         check_eq("frame_8o2", 32'(mism[2]), 32'd0);
      end

      // FIFO fill, stall and contiguous stream of "Hello"
      req[0] = 1'b1;
      data[0] = hello[0];
      n_acc = 0;
      m = 0;
      for (int e = 0; e <= 205; e++) begin
         rdy_b = ready[0];
         step();
         if (req[0] && rdy_b) begin
            n_acc++;
            if (n_acc == 5) req[0] = 1'b0;
            else data[0] = hello[n_acc];
         end
         if (e == 3)   check_eq("stream_ready_e3", 32'(ready[0]), 32'd1);
         if (e == 4) begin
            check_eq("stream_full_ready", 32'(ready[0]), 32'd0);
            check_eq("stream_full_level", 32'(level[0]), 32'd4);
            check_eq("stream_accepts", 32'(n_acc), 32'd5);
         end
         if (e == 41)  check_eq("stream_stall", 32'(ready[0]), 32'd0);
         if (e == 42) begin
            check_eq("stream_pop_ready", 32'(ready[0]), 32'd1);
            check_eq("stream_pop_level", 32'(level[0]), 32'd3);
         end
         if (e == 201) check_eq("stream_busy_last", 32'(busy[0]), 32'd1);
         if (e == 202) check_eq("stream_busy_fall", 32'(busy[0]), 32'd0);
         if (e >= 2) begin
            e_bit = (e <= 201) ? frame_bit(hello[(e-2)/40], 1'b0, 0, ((e-2) % 40) / 4) : 1'b1;
            if (line[0] !== e_bit) m++;
         end
      end
      check_eq("stream_line", 32'(m), 32'd0);

      // Push on the exact STOP->START pop edge
      req[0] = 1'b1;
      data[0] = sp[0];
      m = 0;
      for (int e = 0; e <= 170; e++) begin
         step();
         if (e == 0) data[0] = sp[1];
         if (e == 1) data[0] = sp[2];
         if (e == 2) req[0] = 1'b0;
         if (e == 41) begin
            check_eq("pushpop_before", 32'(level[0]), 32'd2);
            req[0] = 1'b1;
            data[0] = sp[3];
         end
         if (e == 42) begin
            req[0] = 1'b0;
            check_eq("pushpop_after", 32'(level[0]), 32'd2);
         end
         if (e >= 2) begin
            e_bit = ((e-2)/40 < 4) ? frame_bit(sp[(e-2)/40], 1'b0, 0, ((e-2) % 40) / 4) : 1'b1;
            if (line[0] !== e_bit) m++;
         end
      end
      check_eq("pushpop_order", 32'(m), 32'd0);

      // Reset mid-DATA of frame 2 with 2 words queued
      req[0] = 1'b1;
      data[0] = rs[0];
      m = 0;
      for (int e = 0; e <= 57; e++) begin
         step();
         if (e == 0) data[0] = rs[1];
         if (e == 1) data[0] = rs[2];
         if (e == 2) data[0] = rs[3];
         if (e == 3) req[0] = 1'b0;
         if (e >= 2) begin
            e_bit = frame_bit(rs[(e-2)/40], 1'b0, 0, ((e-2) % 40) / 4);
            if (line[0] !== e_bit) m++;
         end
      end
      check_eq("prereset_line", 32'(m), 32'd0);
      check_eq("prereset_level", 32'(level[0]), 32'd2);
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_reset_line", 32'(line[0]), 32'd1);
      check_eq("async_reset_level", 32'(level[0]), 32'd0);
      check_eq("async_reset_ready", 32'(ready[0]), 32'd1);
      check_eq("async_reset_busy", 32'(busy[0]), 32'd0);
      repeat (3) step();
      reset = 1'b0;
      repeat (2) step();
      req[0] = 1'b1;
      data[0] = 8'h55;
      step();
      req[0] = 1'b0;
      m = 0;
      for (int k = 1; k <= 150; k++) begin
         step();
         if (line[0] !== exp_line(8'h55, 1'b0, 0, 1, k)) m++;
      end
      check_eq("post_reset_single_frame", 32'(m), 32'd0);
      check_eq("post_reset_idle_busy", 32'(busy[0]), 32'd0);

      // Randomised stream on 8O2 against the serial receiver
      rx_on = 1'b1;
      sent = 0;
      guard = 0;
      req[2] = 1'b1;
      data[2] = 8'($urandom);
      while (sent < 40 && guard < 20000) begin
         rdy_b = ready[2];
         step();
         guard++;
         if (req[2] && rdy_b) begin
            exp_q.push_back(data[2]);
            sent++;
         end
         if (sent < 40) begin
            req[2] = ($urandom_range(0, 3) != 0);
            data[2] = 8'($urandom);
         end else begin
            req[2] = 1'b0;
         end
      end
      req[2] = 1'b0;
      check_eq("rand_sent", 32'(sent), 32'd40);
      guard = 0;
      while (rx_count < 40 && guard < 4000) begin
         step();
         guard++;
      end
      check_eq("rand_received", 32'(rx_count), 32'd40);
      repeat (10) step();
      check_eq("rand_end_busy", 32'(busy[2]), 32'd0);
      check_eq("rand_end_level", 32'(level[2]), 32'd0);
      check_eq("rand_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
